// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// muldiv_pkg
// Shared ALU opcodes, md_op encodings and sequencer state type.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam logic [3:0] ALU_OP_SLL = 4'b0000;
  localparam logic [3:0] ALU_OP_MUL = 4'b0011;
  localparam logic [3:0] ALU_OP_DIV = 4'b0100;

  localparam logic [2:0] MD_NONE = 3'b000;
  localparam logic [2:0] MD_MULT = 3'b001;
  localparam logic [2:0] MD_DIV  = 3'b010;
  localparam logic [2:0] MD_MTHI = 3'b011;
  localparam logic [2:0] MD_MTLO = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
//------------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle mult/div sequencer driving a shared ALU; owns HI/LO.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        dz
);

  localparam int c_max_cycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_alu_op;
  logic [31:0]          r_alu_x;
  logic [31:0]          r_alu_y;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dz;

  logic w_y_zero;
  logic w_mul;
  logic w_div;
  logic w_div_zero;
  logic w_mthi;
  logic w_mtlo;

  assign w_y_zero   = (y == 32'd0);
  assign w_mul      = start && (md_op == MD_MULT);
  assign w_div      = start && (md_op == MD_DIV) && !w_y_zero;
  assign w_div_zero = start && (md_op == MD_DIV) &&  w_y_zero;
  assign w_mthi     = start && (md_op == MD_MTHI);
  assign w_mtlo     = start && (md_op == MD_MTLO);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_mul || w_div) w_next = RUN;
      RUN:     if (r_cnt == '0)    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers; start is only honoured in IDLE so RUN ignores it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_alu_op <= ALU_OP_SLL;
      r_alu_x  <= '0;
      r_alu_y  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mul || w_div) begin
            r_alu_x  <= x;
            r_alu_y  <= y;
            r_alu_op <= w_mul ? ALU_OP_MUL : ALU_OP_DIV;
            r_cnt    <= w_mul ? c_cnt_w'(MUL_CYCLES - 1) : c_cnt_w'(DIV_CYCLES - 1);
            r_busy   <= 1'b1;
          end else if (w_div_zero) begin
            r_done <= 1'b1;
            r_dz   <= 1'b1;
          end else if (w_mthi) begin
            r_hi   <= x;
            r_done <= 1'b1;
          end else if (w_mtlo) begin
            r_lo   <= x;
            r_done <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_lo     <= alu_r;
            r_hi     <= alu_r2;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_alu_op <= ALU_OP_SLL;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall = r_busy || w_mul || w_div;
  end

  assign alu_op = r_alu_op;
  assign alu_x  = r_alu_x;
  assign alu_y  = r_alu_y;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign busy   = r_busy;
  assign done   = r_done;
  assign dz     = r_dz;

endmodule

`default_nettype wire
